// File: rtl/operand_stage.sv
// operand_stage: register file, hazard scoreboard and registered operand hand-off to the ALU
module operand_stage #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic              in_sub,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [2:0]        out_op,
    output logic [ADDR_W-1:0] out_rd
);
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic              hit1, hit2, stall, fire;
    logic [DATA_W-1:0] src1, src2, opnd2, data2;
    logic [2:0]        op;
    logic [NREG-1:0]   pending_next;

    // source read with write-back bypass, hazard detection and operand formation
    always_comb begin
        hit1     = wb_en && wb_addr == in_rs1;
        hit2     = wb_en && wb_addr == in_rs2;
        src1     = hit1 ? wb_data : regs[in_rs1];
        src2     = hit2 ? wb_data : regs[in_rs2];
        stall    = (pending[in_rs1] && !hit1) || (!in_use_imm && pending[in_rs2] && !hit2);
        in_ready = (!out_valid || out_ready) && !stall;
        fire     = in_valid && in_ready;
        opnd2    = in_use_imm ? in_imm : src2;
        data2    = in_sub ? '0 - opnd2 : opnd2;
        op       = in_sub ? 3'd1 : in_op;
    end

    // scoreboard update: write-back clears, issue sets, and set wins on a collision
    always_comb begin
        pending_next = pending;
        if (wb_en) pending_next[wb_addr] = 1'b0;
        if (fire) pending_next[in_rd] = 1'b1;
    end

    // architectural register file written by the write-back port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // pending bits per register
    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else pending <= pending_next;
    end

    // output register toward the ALU; holds while the consumer back-pressures
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data1 <= '0;
            out_data2 <= '0;
            out_op    <= '0;
            out_rd    <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data1 <= src1;
            out_data2 <= data2;
            out_op    <= op;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed and randomized checks of operand_stage against a behavioural model
module tb_operand_stage;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [2:0] in_op = '0;
    logic       in_sub = 1'b0, in_use_imm = 1'b0;
    logic [7:0] in_imm = '0;
    logic [2:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic       wb_en = 1'b0;
    logic [2:0] wb_addr = '0;
    logic [7:0] wb_data = '0;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_data1, out_data2;
    logic [2:0] out_op, out_rd;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    int mregs [8];
    bit mpend [8];
    bit e_valid;
    int e_d1, e_d2, e_op, e_rd;

    operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sub(in_sub), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data1(out_data1), .out_data2(out_data2), .out_op(out_op), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit wb_hits(int r);
        return wb_en && int'(wb_addr) == r;
    endfunction

    function automatic int value_of(int r);
        return wb_hits(r) ? int'(wb_data) : mregs[r];
    endfunction

    function automatic bit m_ready();
        bit blocked;
        blocked = (mpend[in_rs1] && !wb_hits(in_rs1)) ||
                  (!in_use_imm && mpend[in_rs2] && !wb_hits(in_rs2));
        return (!e_valid || out_ready) && !blocked;
    endfunction

    // reference model advanced at every rising edge from the pre-edge inputs
    always @(posedge clk) begin
        bit fire;
        int o2;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mregs[i] = 0;
                mpend[i] = 0;
            end
            e_valid = 0; e_d1 = 0; e_d2 = 0; e_op = 0; e_rd = 0;
        end else begin
            fire = in_valid && m_ready();
            if (fire) begin
                e_d1 = value_of(in_rs1);
                o2 = in_use_imm ? int'(in_imm) : value_of(in_rs2);
                e_d2 = in_sub ? (256 - o2) % 256 : o2;
                e_op = in_sub ? 1 : int'(in_op);
                e_rd = in_rd;
                e_valid = 1;
            end else if (out_ready) begin
                e_valid = 0;
            end
            if (wb_en) begin
                mregs[wb_addr] = wb_data;
                mpend[wb_addr] = 0;
            end
            if (fire) mpend[in_rd] = 1;
        end
    end

    // every-cycle comparison of DUT against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, m_ready());
            chk("out_valid", out_valid, e_valid);
            chk("out_data1", out_data1, e_d1);
            chk("out_data2", out_data2, e_d2);
            chk("out_op", out_op, e_op);
            chk("out_rd", out_rd, e_rd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input int op,
                         input bit sub, input bit use_imm, input int imm);
        in_valid = 1'b1;
        in_rs1 = 3'(rs1); in_rs2 = 3'(rs2); in_rd = 3'(rd); in_op = 3'(op);
        in_sub = sub; in_use_imm = use_imm; in_imm = 8'(imm);
    endtask

    task automatic wb(input int a, input int d);
        wb_en = 1'b1; wb_addr = 3'(a); wb_data = 8'(d);
    endtask

    initial begin
        cyc();
        started = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_data1", out_data1, 0);

        wb(1, 3); cyc();
        wb(2, 4); cyc();
        wb_en = 1'b0;
        issue(1, 2, 3, 1, 0, 0, 0);
        settle();
        chk("add_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_d1", out_data1, 8'h03);
        chk("add_d2", out_data2, 8'h04);
        chk("add_op", out_op, 1);
        chk("add_rd", out_rd, 3);
        wb(3, 7); cyc();
        wb_en = 1'b0;
        issue(0, 3, 6, 0, 0, 0, 0); cyc();
        in_valid = 1'b0;
        chk("fwd_r3_d2", out_data2, 8'h07);

        wb(1, 5); cyc();
        wb_en = 1'b0;
        issue(1, 0, 7, 2, 1, 1, 8'h03); cyc();
        chk("sub_d1", out_data1, 8'h05);
        chk("sub_d2", out_data2, 8'hFD);
        chk("sub_op", out_op, 1);
        issue(1, 0, 7, 2, 1, 1, 8'h00); cyc();
        chk("sub_zero", out_data2, 8'h00);
        issue(1, 0, 7, 2, 1, 1, 8'h80); cyc();
        chk("sub_min", out_data2, 8'h80);

        issue(0, 0, 4, 0, 0, 1, 1); cyc();
        issue(4, 0, 6, 0, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hazard_stall", in_ready, 0);
            cyc();
        end
        wb(4, 8'h2A);
        settle();
        chk("hazard_bypass_ready", in_ready, 1);
        cyc();
        wb_en = 1'b0;
        in_valid = 1'b0;
        chk("hazard_bypass_d1", out_data1, 8'h2A);
        issue(4, 0, 6, 0, 0, 1, 2);
        settle();
        chk("hazard_cleared", in_ready, 1);
        cyc();

        issue(1, 0, 2, 3, 0, 1, 8'h33); cyc();
        out_ready = 1'b0;
        issue(1, 0, 3, 2, 0, 1, 8'h44);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_d1", out_data1, 8'h05);
            chk("bp_d2", out_data2, 8'h33);
            chk("bp_op", out_op, 3);
            chk("bp_rd", out_rd, 2);
            cyc();
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("bp_replace_valid", out_valid, 1);
        chk("bp_replace_d2", out_data2, 8'h44);
        chk("bp_replace_rd", out_rd, 3);

        issue(0, 0, 5, 0, 0, 1, 0);
        wb(5, 8'h11); cyc();
        wb_en = 1'b0;
        issue(5, 0, 6, 0, 0, 1, 0);
        settle();
        chk("setwins_stall", in_ready, 0);
        cyc();
        wb(5, 8'h22);
        settle();
        chk("setwins_release", in_ready, 1);
        cyc();
        wb_en = 1'b0;
        in_valid = 1'b0;
        chk("setwins_d1", out_data1, 8'h22);

        issue(0, 0, 2, 0, 0, 1, 1); cyc();
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b1; cyc();
        reset = 1'b0;
        settle();
        chk("post_reset_valid", out_valid, 0);
        issue(2, 0, 0, 0, 0, 1, 0);
        settle();
        chk("post_reset_ready", in_ready, 1);
        cyc();
        chk("post_reset_d1", out_data1, 0);
        issue(1, 0, 0, 0, 0, 1, 0); cyc();
        in_valid = 1'b0;
        chk("post_reset_r1", out_data1, 0);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom_range(0, 7));
            in_sub = ($urandom_range(0, 3) == 0);
            in_use_imm = $urandom_range(0, 1) != 0;
            in_imm = 8'($urandom_range(0, 255));
            in_rs1 = 3'($urandom_range(0, 7));
            in_rs2 = 3'($urandom_range(0, 7));
            in_rd = 3'($urandom_range(0, 7));
            wb_en = ($urandom_range(0, 2) == 0);
            wb_addr = 3'($urandom_range(0, 7));
            wb_data = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        wb_en = 1'b0;
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_stage.md
# operand_stage

Operand-fetch stage placed directly upstream of `alu`. Holds the 8 x 8-bit architectural register file. Accepts decoded instructions and reads both source registers, selecting either an immediate or the second register. For subtraction it negates operand 2, and it presents `data1`/`data2`/`operation` to the ALU through a registered valid/ready output. ALU results return on a write-back port, and a per-register pending scoreboard stalls instructions that read a register whose result has not yet been written back.

## Interface
Parameters:
- `DATA_W`, 8, operand/register width
- `NREG`, 8, number of registers; `ADDR_W` = clog2(`NREG`) = 3

Ports:
- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-high
- `in_valid` input 1: decoded instruction present
- `in_ready` output 1: stage accepts instruction this cycle
- `in_op` input 3: ALU op (0 FWD, 1 ADD, 2 AND, 3 OR)
- `in_sub` input 1: subtract; negate operand 2 and force op = ADD
- `in_use_imm` input 1: operand 2 = `in_imm` instead of reg[`in_rs2`]
- `in_imm` input DATA_W: immediate
- `in_rs1`, `in_rs2`, `in_rd` input ADDR_W: source/destination registers
- `wb_en` input 1: write-back strobe
- `wb_addr` input ADDR_W, `wb_data` input DATA_W: write-back target/value
- `out_valid` output 1: ALU operands valid
- `out_ready` input 1: ALU side consumes
- `out_data1`, `out_data2` output DATA_W: to ALU `data1`/`data2`
- `out_op` output 3: to ALU `operation`
- `out_rd` output ADDR_W: destination, carried for write-back

## Operation
- Accept: `fire = in_valid && in_ready`.
- `in_ready = (!out_valid || out_ready) && !stall`.
- `stall` when rs1 is pending and not being written back this cycle. It also stalls when `!in_use_imm` and rs2 is pending and not being written back this cycle.
- "Being written back" means `wb_en && wb_addr == rsX`.
- Read with bypass: the source value is `wb_data` if `wb_en && wb_addr == rsX`; otherwise it is reg[rsX].
- Operand 2 before negation is `in_use_imm ? in_imm : src2`.
- If `in_sub`, `out_data2` = two's-complement negation of operand 2, mod 2^DATA_W (−0 = 0, −0x80 = 0x80). `out_op` is then 1 regardless of `in_op`.
- If not `in_sub`, `out_data2` = operand 2 and `out_op` = `in_op`.
- `out_data1` = src1 value. `out_rd` = `in_rd`.
- On fire, the output register loads these values and `out_valid` sets.
- On `out_valid && out_ready && !fire`, `out_valid` clears.
- Output fields hold stable while `out_valid && !out_ready`.
- Register file: on `wb_en`, reg[`wb_addr`] ← `wb_data` at the edge. All registers are writable, including reg 0.
- Scoreboard, per register:
  - pending[`in_rd`] sets on fire.
  - pending[`wb_addr`] clears on `wb_en`.
  - If both hit the same register in one cycle, set wins.
- `in_op` values 4–7 pass through unchanged.

## Timing
- Reset: all registers 0, all pending bits 0, `out_valid`=0. `out_data1`, `out_data2`, `out_op` and `out_rd` reset to 0.
- `in_ready` is combinational. After reset it reads 1 while `in_valid` is low.
- Latency: one cycle. An instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: one instruction per cycle when `out_ready`=1 and there are no hazards.
- Write-back read-after-write in the same cycle returns the new value through the bypass; no extra stall.
- A dependent instruction is accepted in the same cycle its source's `wb_en` arrives.
- Back-to-back dependency (rd of N = rs of N+1 with no intervening wb) stalls until the wb arrives.
- Reset mid-operation clears the in-flight output and the scoreboard the same edge; a pending wb after reset simply writes the register.
- `wb_en` to a non-pending register is legal: it writes and leaves pending at 0.

## Test plan
- Reset, then wb r1←3, wb r2←4, issue rs1=1 rs2=2 op=1 rd=3 → `out_data1`=0x03, `out_data2`=0x04, `out_op`=1, `out_rd`=3, one cycle after accept; then wb r3←7 and verify reg value 7 by issuing FWD rs2=3 → `out_data2`=0x07.
- SUB: r1=0x05, immediate 0x03, `in_sub`=1, `in_op`=2 → `out_data2`=0xFD, `out_op`=1; also imm 0x00 → 0x00, imm 0x80 → 0x80.
- Hazard: issue rd=4, then an instruction with rs1=4 → `in_ready`=0 for 3 cycles. Assert wb r4←0x2A in cycle 4 → accepted that cycle with `out_data1`=0x2A (bypass), and pending[4] stays 0.
- Backpressure: hold `out_ready`=0 with `out_valid`=1 for 4 cycles → outputs stable, `in_ready`=0; then raise `out_ready` with `in_valid`=1 → new instruction replaces the output in the same edge and `out_valid` stays 1.
- Simultaneous set/clear: in one cycle fire with rd=5 and `wb_en` to r5 → pending[5]=1 afterwards, and the next read of r5 stalls.
- Reset asserted while `out_valid`=1 and pending[2]=1 → next cycle `out_valid`=0, all registers 0, and an rs1=2 instruction is accepted immediately with `out_data1`=0.
